// File: rtl/intpol2_d4_fifo_feeder_pkg.sv
// ============================================================================
// Package : intpol2_d4_fifo_feeder_pkg
// Brief   : State encoding and sizing constants for the intpol2 D4 FIFO feeder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package intpol2_d4_fifo_feeder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;
  localparam int PAD_LEN    = 3;

endpackage

`default_nettype wire

// File: rtl/intpol2_d4_fifo_feeder_skid_buf.sv
// ============================================================================
// Module : intpol2_d4_fifo_feeder_skid_buf
// Brief  : 2-entry register FIFO; entry 0 is always the head, zero when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intpol2_d4_fifo_feeder_skid_buf
  import intpol2_d4_fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [SKID_CNT_W-1:0] cnt_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
  logic                  w_pop;
  logic                  w_full;

  assign w_pop  = pop_i & (cnt_q != '0);
  assign w_full = (cnt_q == SKID_CNT_W'(SKID_DEPTH));

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, w_pop})
      2'b01: begin
        // Shifting a cleared tail keeps the head zero once the buffer drains.
        ent0_d = ent1_q;
        ent1_d = '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (!w_full) begin
          if (cnt_q == '0) ent0_d = data_i;
          else             ent1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = ent0_q;
  assign cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/intpol2_d4_fifo_feeder.sv
// ============================================================================
// Module : intpol2_d4_fifo_feeder
// Brief  : Reads ilen samples from input memory and pushes them into the
//          interpolator FIFO, throttled by afull/full through a 2-entry skid.
//          Optional zero padding enabled by INTPOL2_D4_FEEDER_PAD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intpol2_d4_fifo_feeder
  import intpol2_d4_fifo_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CONFIG_WIDTH = 32,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic [CONFIG_WIDTH-1:0] ilen,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    fifo_afull,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_WIDTH-1:0]   fifo_wdata,
  output logic                    busy,
  output logic                    done
);

  localparam logic [CONFIG_WIDTH-1:0] c_one = {{(CONFIG_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [CONFIG_WIDTH-1:0] len_q, len_d;
  logic [CONFIG_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CONFIG_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                    inflight_q;

  logic                    w_sync_rst;
  logic                    w_run;
  logic                    w_start_ok;
  logic                    w_data_pop;
  logic                    w_pad_push;
  logic                    w_last;
  logic                    w_zero_skip;
  logic                    w_zero_done;
  logic                    w_credit;
  logic [2:0]              w_occ;
  logic [DATA_WIDTH-1:0]   w_skid_head;
  logic [SKID_CNT_W-1:0]   w_skid_cnt;

  assign w_sync_rst = rst | clear;
  assign w_run      = (state_q == S_RUN);
  assign w_start_ok = start & (state_q == S_IDLE) & ~w_zero_done;
  assign w_data_pop = w_run & (w_skid_cnt != '0) & ~fifo_full;

  // A push in the same cycle frees a slot, so sustained rate stays at one sample per cycle.
  assign w_occ    = {1'b0, w_skid_cnt} + {2'b00, inflight_q};
  assign w_credit = (w_occ < (3'(SKID_DEPTH) + {2'b00, w_data_pop}));

  assign mem_rd_en  = w_run & (rd_cnt_q < len_q) & ~fifo_afull & w_credit;
  assign mem_addr   = rd_cnt_q[ADDR_WIDTH-1:0];
  assign fifo_wr_en = w_data_pop | w_pad_push;
  assign fifo_wdata = w_skid_head;
  assign busy       = w_run;
  assign done       = w_last | w_zero_done;

`ifdef INTPOL2_D4_FEEDER_PAD_EN
  logic [1:0] pad_cnt_q, pad_cnt_d;

  // Pads start once every data sample is out; the skid is empty, so the head reads as zero.
  assign w_pad_push  = w_run & (w_skid_cnt == '0) & (wr_cnt_q == len_q)
                     & (pad_cnt_q < 2'(PAD_LEN)) & ~fifo_full;
  assign w_last      = w_pad_push & (pad_cnt_q == 2'(PAD_LEN - 1));
  assign w_zero_skip = 1'b0;
  assign w_zero_done = 1'b0;

  always_comb begin
    pad_cnt_d = pad_cnt_q;
    if (w_start_ok)      pad_cnt_d = '0;
    else if (w_pad_push) pad_cnt_d = pad_cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (w_sync_rst) pad_cnt_q <= '0;
    else            pad_cnt_q <= pad_cnt_d;
  end
`else
  logic zero_done_q;

  assign w_pad_push  = 1'b0;
  assign w_last      = w_data_pop & ((wr_cnt_q + c_one) == len_q);
  assign w_zero_skip = (ilen == '0);
  assign w_zero_done = zero_done_q;

  // A zero-length job spends one cycle in DONE, then pulses done.
  always_ff @(posedge clk) begin
    if (w_sync_rst) zero_done_q <= 1'b0;
    else            zero_done_q <= (state_q == S_DONE) & (len_q == '0);
  end
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_start_ok) begin
          len_d    = ilen;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = w_zero_skip ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (mem_rd_en)  rd_cnt_d = rd_cnt_q + c_one;
        if (w_data_pop) wr_cnt_d = wr_cnt_q + c_one;
        if (w_last)     state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_sync_rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= mem_rd_en;
    end
  end

  intpol2_d4_fifo_feeder_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (w_sync_rst),
    .push_i (inflight_q),
    .pop_i  (w_data_pop),
    .data_i (mem_rdata),
    .head_o (w_skid_head),
    .cnt_o  (w_skid_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_intpol2_d4_fifo_feeder.sv
// ============================================================================
// Module : tb_intpol2_d4_fifo_feeder
// Brief  : Self-checking bench for intpol2_d4_fifo_feeder (order/stall model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intpol2_d4_fifo_feeder;

  localparam int DW = 32;
  localparam int CW = 32;
  localparam int AW = 16;
`ifdef INTPOL2_D4_FEEDER_PAD_EN
  localparam int NPAD = 3;
`else
  localparam int NPAD = 0;
`endif
  localparam int ZERO_DONE_OFS = (NPAD == 0) ? 2 : NPAD;

  logic          clk = 1'b0;
  logic          rst, clear, start, fifo_afull, fifo_full;
  logic [CW-1:0] ilen;
  logic          mem_rd_en, fifo_wr_en, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] fifo_wdata;

  always #5 clk = ~clk;

  intpol2_d4_fifo_feeder #(.DATA_WIDTH(DW), .CONFIG_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .ilen(ilen),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fifo_afull(fifo_afull), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata), .busy(busy), .done(done)
  );

  // Input memory: sample at address a is a+100, one cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= DW'(mem_addr) + DW'(100);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: expected push stream (-1 marks a zero pad) plus the transfer status.
  int exp_q[$];
  bit m_active = 0, m_done_state = 0, m_chk_zero = 0;
  int m_zero_due = -1, m_next_addr = 0, m_reads_left = 0, m_outstanding = 0;
  int first_push_cyc = -1, done_cyc = -1, n_reads = 0, n_pushes = 0;

  always @(negedge clk) begin
    bit last, done_exp, accept;
    int v;
    last = 0;
    if (m_chk_zero) begin
      chk("rst_mem_rd_en", mem_rd_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_fifo_wr_en", fifo_wr_en, 0);
      chk("rst_fifo_wdata", fifo_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    m_chk_zero = rst | clear;
    chk("busy", busy, m_active);
    if (mem_rd_en) begin
      n_reads++;
      chk("rd_while_afull", fifo_afull, 0);
      chk("rd_allowed", m_reads_left > 0, 1);
      chk("rd_addr", mem_addr, m_next_addr & 16'hFFFF);
      m_next_addr++;
      m_reads_left--;
      m_outstanding++;
    end
    if (fifo_wr_en) begin
      n_pushes++;
      if (first_push_cyc < 0) first_push_cyc = cyc;
      chk("push_while_full", fifo_full, 0);
      chk("push_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        v = exp_q.pop_front();
        chk("push_data", fifo_wdata, (v < 0) ? 0 : v);
        if (v >= 0) m_outstanding--;
        if (m_active && exp_q.size() == 0) last = 1;
      end
    end
    chk("outstanding_le_2", m_outstanding <= 2, 1);
    done_exp = last || (cyc == m_zero_due);
    chk("done", done, done_exp);
    if (done) done_cyc = cyc;

    accept = start && !m_active && !m_done_state && !done_exp;
    m_done_state = last;
    if (last) m_active = 0;
    if (accept) begin
      m_next_addr   = 0;
      m_reads_left  = int'(ilen);
      m_outstanding = 0;
      for (int i = 0; i < int'(ilen); i++) exp_q.push_back(100 + i);
      for (int i = 0; i < NPAD; i++) exp_q.push_back(-1);
      if (ilen == 0 && NPAD == 0) begin
        m_zero_due   = cyc + 2;
        m_done_state = 1;
      end else begin
        m_active = 1;
      end
    end
    if (rst || clear) begin
      exp_q.delete();
      m_active = 0; m_done_state = 0; m_zero_due = -1;
      m_reads_left = 0; m_outstanding = 0;
    end
  end

  int f_lo = -1, f_hi = -2, a_lo = -1, a_hi = -2;

  task automatic step();
    @(posedge clk); #1;
    start = 0; rst = 0; clear = 0;
    fifo_full  = (cyc >= f_lo && cyc <= f_hi);
    fifo_afull = (cyc >= a_lo && cyc <= a_hi);
  endtask

  task automatic clear_rec();
    first_push_cyc = -1; done_cyc = -1; n_reads = 0; n_pushes = 0;
  endtask

  task automatic launch(input int len, output int t);
    step();
    clear_rec();
    start = 1;
    ilen  = CW'(len);
    t     = cyc;
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      step();
      idle = !m_active && !m_done_state && exp_q.size() == 0 && m_zero_due < cyc;
    end
    chk("wait_idle_timeout", idle, 1);
  endtask

  task automatic abort_at_push5(input bit use_clear);
    int t;
    launch(16, t);
    for (int i = 0; i < 40 && n_pushes < 4; i++) step();
    if (use_clear) clear = 1; else rst = 1;
    repeat (4) step();
    chk(use_clear ? "clear_no_done" : "rst_no_done", done_cyc, -1);
    chk(use_clear ? "clear_pushes" : "rst_pushes", n_pushes, 5);
    launch(4, t);
    wait_idle(40);
    chk("restart_pushes", n_pushes, 4 + NPAD);
    chk("restart_first_push", first_push_cyc, t + 3);
  endtask

  initial begin
    int t;
    rst = 1; clear = 0; start = 0; ilen = '0; fifo_afull = 0; fifo_full = 0;
    repeat (2) begin @(posedge clk); #1; end
    step();

    // 1: free-running transfer
    launch(8, t);
    wait_idle(60);
    chk("t1_first_push", first_push_cyc, t + 3);
    chk("t1_done_cycle", done_cyc, t + 10 + NPAD);
    chk("t1_pushes", n_pushes, 8 + NPAD);
    chk("t1_reads", n_reads, 8);

    // 2: FIFO full stall
    launch(8, t);
    f_lo = t + 4; f_hi = t + 9;
    wait_idle(60);
    chk("t2_pushes", n_pushes, 8 + NPAD);
    chk("t2_reads", n_reads, 8);
    f_lo = -1; f_hi = -2;

    // 3: almost-full throttle
    launch(6, t);
    a_lo = t + 2; a_hi = t + 5;
    wait_idle(60);
    chk("t3_pushes", n_pushes, 6 + NPAD);
    chk("t3_reads", n_reads, 6);
    a_lo = -1; a_hi = -2;

    // 4: zero length, plus a start coinciding with done
    launch(0, t);
    step(); step();
    start = 1; ilen = CW'(2);
    wait_idle(30);
    chk("t4_done_cycle", done_cyc, t + ZERO_DONE_OFS);
    chk("t4_reads", n_reads, 0);
    chk("t4_pushes", n_pushes, NPAD);

    // 5: abort mid-transfer with rst, then with clear
    abort_at_push5(1'b0);
    abort_at_push5(1'b1);

    // 6: start re-pulsed while running
    launch(8, t);
    repeat (3) step();
    start = 1; ilen = CW'(3);
    wait_idle(60);
    chk("t6_pushes", n_pushes, 8 + NPAD);
    chk("t6_reads", n_reads, 8);
    chk("t6_done_cycle", done_cyc, t + 10 + NPAD);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
